immediate_encoder: RTL
======================

# immediate_encoder

Sequential encoder for the accumulator processor. It takes 16-bit constants and emits the shortest instruction sequence that loads each constant into the accumulator. It is the inverse of `immediate_generator`: every emitted instruction, decoded by `immediate_generator`, reproduces the requested constant. It sits between the assembler/boot-loader front end and instruction memory, with valid/ready on both sides.

## Interface
- `DATA_W`, default 16: instruction and constant width; only 16 is supported.
- `CLK` input 1: single clock; all state updates on the rising edge.
- `Reset` input 1: synchronous, active-high.
- `in_valid` input 1: `in_value` holds a constant to encode.
- `in_value` input 16: constant to load.
- `in_ready` output 1: the encoder accepts `in_value` this cycle.
- `out_valid` output 1: `out_instr` is valid.
- `out_ready` input 1: downstream consumes `out_instr` this cycle.
- `out_instr` output 16: encoded instruction; opcode in [15:12], immediate field in [11:0].
- `out_last` output 1: `out_instr` is the final instruction for the current constant.
- `instr_count` output 16: number of output handshakes; wraps modulo 2^16.

## Operation
- Opcodes:
  - `OP_LI`=4'h1: acc = sign-extend(imm[11:0]).
  - `OP_LUI`=4'h2: acc = imm[7:0]<<8.
  - `OP_ORI`=4'h3: acc |= zero-extend(imm[7:0]).
  - imm[11:8] is 0 for LUI and ORI.
- Fit rule: a constant is "short" when in_value[15:11] is all-0 or all-1, i.e. the range -2048..2047.
  - Short: one instruction, {OP_LI, v[11:0]}, `out_last`=1.
  - Long: two instructions, {OP_LUI, 4'h0, v[15:8]} (`out_last`=0), then {OP_ORI, 4'h0, v[7:0]} (`out_last`=1).
- FSM states and transitions:
  - IDLE: accept when in_valid & in_ready. Go to SINGLE if short, HI if long.
  - SINGLE: on out handshake, go to IDLE, or to SINGLE/HI if a new constant is accepted in the same cycle.
  - HI: on out handshake, go to LO.
  - LO: on out handshake, behaves like SINGLE.
- `in_value` is captured into an internal register on acceptance; later changes on `in_value` do not affect the constant being encoded.
- `in_ready` = (state==IDLE) | (out_valid & out_ready & out_last). This allows back-to-back constants with no bubble.
- `out_valid` is high in SINGLE, HI and LO. It is low only in IDLE.
- `instr_count` increments on every out_valid & out_ready. 0xFFFF wraps to 0x0000.

## Timing
- Reset values: state IDLE, `out_valid`=0, `out_instr`=16'h0000, `out_last`=0, `instr_count`=0. `in_ready`=1 in the cycle after reset deasserts.
- Reset while a constant is mid-sequence (HI or LO) discards it. No further instruction for that constant is emitted.
- Latency: constant accepted at edge N gives `out_valid`=1 with the first instruction after edge N.
- `out_instr`, `out_last` and `out_valid` are registered. They hold stable while out_valid & !out_ready, so backpressure of any length is legal.
- Simultaneous last-instruction handshake and new acceptance: the next instruction appears the following cycle; `out_valid` stays high with no gap.
- Throughput: 1 constant/cycle for short constants, 1 constant per 2 cycles for long constants.
- `in_ready` depends combinationally on `out_ready`. Downstream must not make `out_ready` depend on `in_ready`.

## Structure
- Shared package `isa_pkg` holds:
  - `OP_LI`, `OP_LUI`, `OP_ORI`;
  - opcode field position [15:12] and immediate field width 12;
  - the FSM state enum.
- `immediate_generator` uses the same opcode constants, so encoder and decoder cannot diverge.
- One combinational sub-module, `imm_fit_check` (16-bit in, 1-bit short out), is natural. It is reused by the assembler front end.

## Test plan
- 0x07FF -> single {0x17FF, last=1}. 0xF800 -> {0x1800, last=1}. 0xFFFF -> {0x1FFF, last=1}.
- 0x0800 -> {0x2008, last=0} then {0x3000, last=1}. 0x1234 -> {0x2012} then {0x3034}.
- `out_ready` low for 5 cycles during HI of 0x1234: `out_instr` held at 0x2012 and `in_ready`=0 throughout. Release gives 0x3034 next cycle.
- Back-to-back stream 0x0005, 0x0800, 0x0006 with `out_ready`=1:
  - output is 0x1005, 0x2008, 0x3000, 0x1006 on consecutive cycles, no bubbles;
  - `instr_count` ends at 4.
- `Reset` asserted while in LO of 0x1234: next cycle `out_valid`=0, `instr_count`=0, `in_ready`=1, and no 0x3034 appears.
- Round trip: 1000 random constants, each sequence executed on the `immediate_generator`+accumulator model, final acc == constant. Also preload `instr_count` to 0xFFFF and confirm it wraps to 0x0000.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the accumulator processor.
// Holds the opcode encodings, instruction field geometry and the encoder
// FSM state type, so the encoder and immediate_generator decode identically.
package isa_pkg;

   localparam int unsigned INSTR_W = 16;
   localparam int unsigned OP_MSB  = 15;
   localparam int unsigned OP_LSB  = 12;
   localparam int unsigned IMM_W   = 12;

   localparam logic [3:0] OP_LI  = 4'h1;  // acc = sext(imm[11:0])
   localparam logic [3:0] OP_LUI = 4'h2;  // acc = imm[7:0] << 8
   localparam logic [3:0] OP_ORI = 4'h3;  // acc |= zext(imm[7:0])

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SINGLE,
      ST_HI,
      ST_LO
   } enc_state_t;

   function automatic logic [INSTR_W-1:0] make_instr(input logic [3:0] op,
                                                     input logic [IMM_W-1:0] imm);
      logic [INSTR_W-1:0] instr;
      instr                 = '0;
      instr[OP_MSB:OP_LSB]  = op;
      instr[IMM_W-1:0]      = imm;
      return instr;
   endfunction

endpackage

// File: rtl/imm_fit_check.sv
// Combinational fit test: a 16-bit constant is "short" when it fits a
// sign-extended 12-bit immediate (-2048..2047), i.e. bits [15:11] agree.
// Ports:
//   value     : constant under test
//   short_fit : 1 when a single LI instruction can load value
module imm_fit_check
   import isa_pkg::*;
(
   input  logic [15:0] value,
   output logic        short_fit
);

   assign short_fit = (value[15:11] == '0) | (value[15:11] == '1);

endmodule

// File: rtl/immediate_encoder.sv
// Sequential immediate encoder: turns each accepted 16-bit constant into the
// shortest LI or LUI+ORI sequence that loads it into the accumulator.
// Ports:
//   CLK, Reset          : clock, synchronous active-high reset
//   in_valid/in_ready   : constant handshake, in_value is the constant
//   out_valid/out_ready : instruction handshake
//   out_instr, out_last : registered instruction and end-of-sequence flag
//   instr_count         : number of output handshakes, wraps mod 2^16
module immediate_encoder
   import isa_pkg::*;
#(
   parameter int unsigned DATA_W = 16
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_value,
   output logic              in_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_instr,
   output logic              out_last,
   output logic [DATA_W-1:0] instr_count
);

   enc_state_t        state, state_n;
   logic [DATA_W-1:0] instr_q, instr_n;
   logic              last_q, last_n;
   logic [7:0]        lo_q, lo_n;       // only the low byte is needed after LUI
   logic [DATA_W-1:0] count_q;
   logic              short_fit;
   logic              out_fire;
   logic              accept;

   imm_fit_check u_fit (
      .value     (in_value),
      .short_fit (short_fit)
   );

   assign out_valid   = (state != ST_IDLE);
   assign out_instr   = instr_q;
   assign out_last    = last_q;
   assign instr_count = count_q;

   assign out_fire = out_valid & out_ready;
   // Accepting on the final handshake keeps out_valid continuous between constants.
   assign in_ready = (state == ST_IDLE) | (out_fire & last_q);
   assign accept   = in_valid & in_ready;

   always_comb begin
      state_n = state;
      instr_n = instr_q;
      last_n  = last_q;
      lo_n    = lo_q;
      if (accept) begin
         lo_n = in_value[7:0];
         if (short_fit) begin
            state_n = ST_SINGLE;
            instr_n = make_instr(OP_LI, in_value[11:0]);
            last_n  = 1'b1;
         end else begin
            state_n = ST_HI;
            instr_n = make_instr(OP_LUI, {4'h0, in_value[15:8]});
            last_n  = 1'b0;
         end
      end else if (out_fire) begin
         unique case (state)
            ST_HI: begin
               state_n = ST_LO;
               instr_n = make_instr(OP_ORI, {4'h0, lo_q});
               last_n  = 1'b1;
            end
            default: state_n = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state   <= ST_IDLE;
         instr_q <= '0;
         last_q  <= 1'b0;
         lo_q    <= '0;
         count_q <= '0;
      end else begin
         state   <= state_n;
         instr_q <= instr_n;
         last_q  <= last_n;
         lo_q    <= lo_n;
         if (out_fire) count_q <= count_q + 1'b1;
      end
   end

endmodule
